// File: rtl/fir_pkg.sv
// Shared constants, bus payload type, FSM encodings and arithmetic helpers
// for the 5-tap FIR subsystem.
package fir_pkg;

  localparam int unsigned NUM_TAPS = 5;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ACC_W    = 16;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned TAP_W    = 3;
  localparam int unsigned SHIFT    = 7;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  localparam logic signed [DATA_W-1:0] COEFS [NUM_TAPS] =
    '{8'sd16, 8'sd24, 8'sd48, 8'sd24, 8'sd16};

  typedef enum logic [3:0] {
    NP_IDLE  = 4'd0,
    NP_CLEAR = 4'd1,
    NP_FETCH = 4'd2,
    NP_MAC   = 4'd3,
    NP_WRITE = 4'd4,
    NP_NEXT  = 4'd5,
    NP_DONE  = 4'd6
  } np_state_e;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_RUN   = 3'd1,
    P_DRAIN = 3'd2,
    P_DONE  = 3'd3
  } p_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  // Sign-extend both operands so the product keeps its sign in the accumulator.
  function automatic logic signed [ACC_W-1:0] tap_product(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] h
  );
    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] he;
    xe = ACC_W'(x);
    he = ACC_W'(h);
    return xe * he;
  endfunction

  function automatic logic [DATA_W-1:0] scale_result(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> SHIFT;
    return sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// 1024x8 sample memory: port A synchronous read (plus write), port B write.
module dual_port_ram
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  input  logic [DATA_W-1:0] data_in_a,
  output logic [DATA_W-1:0] data_out_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic [DATA_W-1:0] data_in_b
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_out_a_q;
  logic [DATA_W-1:0] data_out_a_d;

  always_comb data_out_a_d = mem[addr_a];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_in_a;
    if (we_b) mem[addr_b] <= data_in_b;
    data_out_a_q <= data_out_a_d;
  end

  assign data_out_a = data_out_a_q;

endmodule

// File: rtl/fir_non_pipelined.sv
// Sequential multiply-accumulate FIR engine: one tap per FETCH/MAC pair,
// 13 cycles per output sample.
module fir_non_pipelined
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [ADDR_W-1:0] sample_count,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr_c,
  output mem_wr_t           wr_c,
  output logic              busy_c,
  output logic              finish_c,
  output np_state_e         state
);

  np_state_e               state_q, state_d;
  logic [ADDR_W-1:0]       in_base_q, in_base_d;
  logic [ADDR_W-1:0]       out_base_q, out_base_d;
  logic [ADDR_W-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]       n_q, n_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NP_IDLE;
      in_base_q  <= '0;
      out_base_q <= '0;
      count_q    <= '0;
      n_q        <= '0;
      tap_q      <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      count_q    <= count_d;
      n_q        <= n_d;
      tap_q      <= tap_d;
      acc_q      <= acc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    count_d    = count_q;
    n_d        = n_q;
    tap_d      = tap_q;
    acc_d      = acc_q;
    rd_addr_c  = in_base_q + n_q - ADDR_W'(tap_q);
    wr_c       = '0;
    busy_c     = 1'b0;
    finish_c   = 1'b0;
    unique case (state_q)
      NP_IDLE, NP_DONE: begin
        if (go_i) begin
          state_d    = NP_CLEAR;
          in_base_d  = input_addr;
          out_base_d = output_addr;
          count_d    = sample_count;
          n_d        = '0;
        end else if (clr_i) begin
          state_d = NP_IDLE;
        end
      end
      NP_CLEAR: begin
        busy_c = 1'b1;
        acc_d  = '0;
        tap_d  = '0;
        if (count_q == '0) begin
          state_d  = NP_DONE;
          finish_c = 1'b1;
        end else begin
          state_d = NP_FETCH;
        end
      end
      NP_FETCH: begin
        busy_c  = 1'b1;
        state_d = NP_MAC;
      end
      NP_MAC: begin
        busy_c = 1'b1;
        // Taps reaching before the first sample contribute zero.
        if (ADDR_W'(tap_q) <= n_q) acc_d = acc_q + tap_product(rd_data, COEFS[tap_q]);
        if (tap_q < TAP_W'(NUM_TAPS - 1)) begin
          tap_d   = tap_q + TAP_W'(1);
          state_d = NP_FETCH;
        end else begin
          state_d = NP_WRITE;
        end
      end
      NP_WRITE: begin
        busy_c    = 1'b1;
        wr_c.we   = 1'b1;
        wr_c.addr = out_base_q + n_q;
        wr_c.data = scale_result(acc_q);
        state_d   = NP_NEXT;
      end
      NP_NEXT: begin
        busy_c = 1'b1;
        n_d    = n_q + ADDR_W'(1);
        if (n_d == count_q) begin
          state_d  = NP_DONE;
          finish_c = 1'b1;
        end else begin
          state_d = NP_CLEAR;
        end
      end
      default: state_d = NP_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/fir_pipelined.sv
// Three-stage pipelined FIR engine: one read per cycle, shift register (s1),
// products and sum (s2), scaled result (s3) written the following cycle.
module fir_pipelined
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [ADDR_W-1:0] sample_count,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr_c,
  output mem_wr_t           wr_c,
  output logic              busy_c,
  output logic              finish_c,
  output p_state_e          state
);

  p_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]        in_base_q, in_base_d, out_base_q, out_base_d;
  logic [ADDR_W-1:0]        count_q, count_d, rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [1:0]               drain_q, drain_d;
  logic                     rd_valid_q, rd_valid_d;
  logic signed [DATA_W-1:0] x0_s1_q, x1_s1_q, x2_s1_q, x3_s1_q, x4_s1_q;
  logic signed [DATA_W-1:0] x0_s1_d, x1_s1_d, x2_s1_d, x3_s1_d, x4_s1_d;
  logic                     valid_s1_q, valid_s1_d, valid_s2_q, valid_s2_d;
  logic signed [ACC_W-1:0]  sum_s2_q, sum_s2_d;
  logic [DATA_W-1:0]        result_s3_q, result_s3_d;
  logic                     output_valid_s3_q, output_valid_s3_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P_IDLE;
      {in_base_q, out_base_q, count_q, rd_idx_q, wr_idx_q} <= '0;
      drain_q <= '0;
      rd_valid_q <= 1'b0;
      {x0_s1_q, x1_s1_q, x2_s1_q, x3_s1_q, x4_s1_q} <= '0;
      {valid_s1_q, valid_s2_q, output_valid_s3_q} <= '0;
      sum_s2_q <= '0;
      result_s3_q <= '0;
    end else begin
      state_q <= state_d;
      {in_base_q, out_base_q, count_q, rd_idx_q, wr_idx_q} <=
        {in_base_d, out_base_d, count_d, rd_idx_d, wr_idx_d};
      drain_q <= drain_d;
      rd_valid_q <= rd_valid_d;
      {x0_s1_q, x1_s1_q, x2_s1_q, x3_s1_q, x4_s1_q} <=
        {x0_s1_d, x1_s1_d, x2_s1_d, x3_s1_d, x4_s1_d};
      {valid_s1_q, valid_s2_q, output_valid_s3_q} <= {valid_s1_d, valid_s2_d, output_valid_s3_d};
      sum_s2_q <= sum_s2_d;
      result_s3_q <= result_s3_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    count_d    = count_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    drain_d    = drain_q;
    rd_valid_d = 1'b0;
    busy_c     = 1'b0;
    finish_c   = 1'b0;
    rd_addr_c  = in_base_q + rd_idx_q;
    // Pipeline datapath advances every cycle; start overrides below.
    {x0_s1_d, x1_s1_d, x2_s1_d, x3_s1_d, x4_s1_d} = {x0_s1_q, x1_s1_q, x2_s1_q, x3_s1_q, x4_s1_q};
    if (rd_valid_q) begin
      {x0_s1_d, x1_s1_d, x2_s1_d, x3_s1_d, x4_s1_d} = {rd_data, x0_s1_q, x1_s1_q, x2_s1_q, x3_s1_q};
    end
    valid_s1_d = rd_valid_q;
    sum_s2_d   = tap_product(x0_s1_q, COEFS[0]) + tap_product(x1_s1_q, COEFS[1])
               + tap_product(x2_s1_q, COEFS[2]) + tap_product(x3_s1_q, COEFS[3])
               + tap_product(x4_s1_q, COEFS[4]);
    valid_s2_d = valid_s1_q;
    result_s3_d       = scale_result(sum_s2_q);
    output_valid_s3_d = valid_s2_q;
    wr_c.we   = output_valid_s3_q;
    wr_c.addr = out_base_q + wr_idx_q;
    wr_c.data = result_s3_q;
    if (output_valid_s3_q) wr_idx_d = wr_idx_q + ADDR_W'(1);
    unique case (state_q)
      P_IDLE, P_DONE: begin
        if (go_i) begin
          state_d    = P_RUN;
          in_base_d  = input_addr;
          out_base_d = output_addr;
          count_d    = sample_count;
          rd_idx_d   = '0;
          wr_idx_d   = '0;
          {x0_s1_d, x1_s1_d, x2_s1_d, x3_s1_d, x4_s1_d} = '0;
          {valid_s1_d, valid_s2_d, output_valid_s3_d} = '0;
        end else if (clr_i) begin
          state_d = P_IDLE;
        end
      end
      P_RUN: begin
        busy_c = 1'b1;
        if (count_q == '0) begin
          state_d  = P_DONE;
          finish_c = 1'b1;
        end else begin
          rd_valid_d = 1'b1;
          rd_idx_d   = rd_idx_q + ADDR_W'(1);
          if (rd_idx_d == count_q) begin
            state_d = P_DRAIN;
            drain_d = '0;
          end
        end
      end
      P_DRAIN: begin
        busy_c  = 1'b1;
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          state_d  = P_DONE;
          finish_c = 1'b1;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/fir_filter_top.sv
// 5-tap FIR subsystem: sample memory, two engines, memory mux, run timer.
// FIR_STATE_DEBUG_EN exposes the live FSM encodings on the state outputs.
module fir_filter_top
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel_pipelined,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [ADDR_W-1:0] sample_count,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [3:0]        non_pipe_state,
  output logic [2:0]        pipe_state
);

  logic              accept_c;
  logic              sel_q, sel_d, done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] np_rd_addr_c, p_rd_addr_c;
  mem_wr_t           np_wr_c, p_wr_c, mem_wr_c;
  logic              np_busy_c, p_busy_c, np_finish_c, p_finish_c;
  np_state_e         np_state;
  p_state_e          p_state;
  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
  logic [DATA_W-1:0] mem_data_out_a, mem_data_in_b;
  logic              mem_we_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  // Start acceptance, done flag and busy-cycle timer.
  always_comb begin
    accept_c = start && !np_busy_c && !p_busy_c;
    sel_d    = sel_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    if (accept_c) begin
      sel_d  = sel_pipelined;
      done_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (np_busy_c || p_busy_c) cnt_d = cnt_q + CNT_W'(1);
      if (np_finish_c || p_finish_c) done_d = 1'b1;
    end
  end

  // Writes are suppressed while reset is held so an abort commits nothing.
  always_comb begin
    mem_wr_c      = sel_q ? p_wr_c : np_wr_c;
    mem_addr_a    = sel_q ? p_rd_addr_c : np_rd_addr_c;
    mem_addr_b    = mem_wr_c.addr;
    mem_data_in_b = mem_wr_c.data;
    mem_we_b      = mem_wr_c.we && !rst;
  end

  dual_port_ram memory (
    .clk        (clk),
    .addr_a     (mem_addr_a),
    .we_a       (1'b0),
    .data_in_a  ('0),
    .data_out_a (mem_data_out_a),
    .addr_b     (mem_addr_b),
    .we_b       (mem_we_b),
    .data_in_b  (mem_data_in_b)
  );

  fir_non_pipelined non_pipelined_filter (
    .clk          (clk),
    .rst          (rst),
    .go_i         (accept_c && !sel_pipelined),
    .clr_i        (accept_c),
    .input_addr   (input_addr),
    .output_addr  (output_addr),
    .sample_count (sample_count),
    .rd_data      (mem_data_out_a),
    .rd_addr_c    (np_rd_addr_c),
    .wr_c         (np_wr_c),
    .busy_c       (np_busy_c),
    .finish_c     (np_finish_c),
    .state        (np_state)
  );

  fir_pipelined pipelined_filter (
    .clk          (clk),
    .rst          (rst),
    .go_i         (accept_c && sel_pipelined),
    .clr_i        (accept_c),
    .input_addr   (input_addr),
    .output_addr  (output_addr),
    .sample_count (sample_count),
    .rd_data      (mem_data_out_a),
    .rd_addr_c    (p_rd_addr_c),
    .wr_c         (p_wr_c),
    .busy_c       (p_busy_c),
    .finish_c     (p_finish_c),
    .state        (p_state)
  );

  assign done        = done_q;
  assign cycle_count = cnt_q;

`ifdef FIR_STATE_DEBUG_EN
  assign non_pipe_state = 4'(np_state);
  assign pipe_state     = 3'(p_state);
`else
  logic state_unused_c;
  assign state_unused_c = ^{np_state, p_state};
  assign non_pipe_state = '0;
  assign pipe_state     = '0;
`endif

endmodule

// File: tb/tb_fir_filter_top.sv
// Scoreboard bench for fir_filter_top: an arithmetic FIR model queues the
// expected port-B writes, a monitor pops and compares each write the DUT makes.
module tb_fir_filter_top;

  logic        clk = 1'b0;
  logic        rst, start, sel_pipelined;
  logic [9:0]  input_addr, output_addr, sample_count;
  logic        done;
  logic [31:0] cycle_count;
  logic [3:0]  non_pipe_state;
  logic [2:0]  pipe_state;

  typedef struct {int addr; int data;} wr_t;

  int       checks = 0;
  int       fails  = 0;
  int       waited = 0;
  logic [7:0] ref_mem [1024];
  wr_t      exp_q[$];
  int       hcoef [5] = '{16, 24, 48, 24, 16};
  int       ref_tbl [20] = '{8, 20, 44, 56, 64, 56, 44, 20, 8, 0, 4, 10, 22, 28, 32, 28, 22, 10, 4, 0};

  fir_filter_top dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sel_pipelined  (sel_pipelined),
    .input_addr     (input_addr),
    .output_addr    (output_addr),
    .sample_count   (sample_count),
    .done           (done),
    .cycle_count    (cycle_count),
    .non_pipe_state (non_pipe_state),
    .pipe_state     (pipe_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every port-B write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && dut.mem_we_b) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got write of %0d to %0d, expected no write",
                 dut.mem_data_in_b, dut.mem_addr_b);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", int'(dut.mem_addr_b), e.addr);
        check("wr_data", int'(dut.mem_data_in_b), e.data);
        ref_mem[e.addr] = 8'(e.data);
      end
    end
  end

  // Reference: y[n] = sum h[k]*x[n-k], x[<0]=0, floor-divide by 128, low 8 bits.
  task automatic push_expected(input int in_a, input int out_a, input int n);
    for (int i = 0; i < n; i++) begin
      int  acc;
      wr_t w;
      acc = 0;
      for (int k = 0; k < 5; k++)
        if (i - k >= 0) acc += hcoef[k] * int'($signed(ref_mem[(in_a + i - k) % 1024]));
      w.addr = (out_a + i) % 1024;
      w.data = (acc >>> 7) & 255;
      exp_q.push_back(w);
    end
  endtask

  task automatic preload();
    for (int a = 0; a < 1024; a++) begin
      logic [7:0] v;
      v = (a < 5) ? 8'd64 : ((a >= 10 && a < 15) ? 8'd32 : 8'd0);
      ref_mem[a] = v;
      dut.memory.mem[a] = v;
    end
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      ref_mem[a] = v;
      dut.memory.mem[a] = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    waited++;
  endtask

  task automatic launch(input logic s, input int ia, input int oa, input int n);
    push_expected(ia, oa, n);
    sel_pipelined = s;
    input_addr    = 10'(ia);
    output_addr   = 10'(oa);
    sample_count  = 10'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    waited = 0;
  endtask

  task automatic finish_run(input string tag, input logic s, input int n);
    int exp_cyc;
    exp_cyc = (n == 0) ? 1 : (s ? n + 4 : 13 * n);
    while (!done && waited < exp_cyc + 64) tick();
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_latency"}, waited, exp_cyc);
    check({tag, "_cycle_count"}, int'(cycle_count), exp_cyc);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic run(input logic s, input int ia, input int oa, input int n, input string tag);
    launch(s, ia, oa, n);
    finish_run(tag, s, n);
  endtask

  task automatic sweep(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 1024; a++) if (dut.memory.mem[a] !== ref_mem[a]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_idle_after_reset(input string tag);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cycle_count"}, int'(cycle_count), 0);
    check({tag, "_np_fsm"}, int'(dut.non_pipelined_filter.state_q), 0);
    check({tag, "_p_fsm"}, int'(dut.pipelined_filter.state_q), 0);
    check({tag, "_state_ports"}, int'({non_pipe_state, pipe_state}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sel_pipelined = 1'b0;
    input_addr = '0; output_addr = '0; sample_count = '0;
    preload();
    repeat (3) @(posedge clk);
    #1;
    check_idle_after_reset("reset");
    rst = 1'b0;
    tick();

    // Directed runs against the published output table.
    run(1'b0, 0, 512, 20, "np20");
    for (int i = 0; i < 20; i++) check("np20_table", int'(dut.memory.mem[512 + i]), ref_tbl[i]);
    run(1'b1, 0, 600, 20, "p20");
    for (int i = 0; i < 20; i++) check("p20_table", int'(dut.memory.mem[600 + i]), ref_tbl[i]);

    // Back-to-back start while done is high.
    launch(1'b1, 8, 650, 5);
    check("b2b_done_low", int'(done), 0);
    check("b2b_count_restart", int'(cycle_count), 0);
    finish_run("b2b", 1'b1, 5);

    // Start while busy is ignored.
    launch(1'b0, 0, 660, 4);
    repeat (10) tick();
    sel_pipelined = 1'b1; output_addr = 10'd900; sample_count = 10'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_p_fsm_idle", int'(dut.pipelined_filter.state_q), 0);
    finish_run("busy", 1'b0, 4);

    // Zero-length runs.
    run(1'b0, 0, 800, 0, "np_n0");
    run(1'b1, 0, 800, 0, "p_n0");

    // Reset mid-run on each engine; committed writes must survive.
    launch(1'b0, 0, 512, 20);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    check_idle_after_reset("np_abort");
    check("np_abort_pending", exp_q.size(), 18);
    exp_q.delete();
    rst = 1'b0;
    tick();
    launch(1'b1, 0, 700, 20);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check_idle_after_reset("p_abort");
    check("p_abort_pending", exp_q.size(), 18);
    exp_q.delete();
    rst = 1'b0;
    tick();
    sweep("abort_mem");

    // Output address wrap-around.
    run(1'b0, 10, 1020, 8, "np_wrap");
    run(1'b1, 10, 1020, 8, "p_wrap");
    check("wrap_1020", int'(dut.memory.mem[1020]), 4);
    check("wrap_0", int'(dut.memory.mem[0]), 32);
    check("wrap_3", int'(dut.memory.mem[3]), 10);

    // Randomised signed data, lengths, addresses and engine choice.
    for (int r = 0; r < 6; r++) begin
      int   n, ia, oa;
      logic s;
      fill_random(100, 260);
      n  = $urandom_range(1, 40);
      ia = $urandom_range(100, 200);
      oa = $urandom_range(700, 980);
      s  = 1'($urandom_range(0, 1));
      run(s, ia, oa, n, $sformatf("rand%0d", r));
    end

    sweep("final_mem");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fir_filter_top.md
# fir_filter_top

Top-level 5-tap FIR filter subsystem. It holds a 1024×8 dual-port sample memory and two filter engines that compute identical results: a sequential (non-pipelined) multiply-accumulate engine and a 3-stage pipelined engine. On `start`, the engine chosen by `sel_pipelined` filters `sample_count` samples from `input_addr` and writes them to `output_addr`. It then reports `done` and the elapsed cycle count, which lets the two architectures be benchmarked against each other.

## Interface
- No parameters. Taps are fixed; see Operation.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; accepted only in IDLE/DONE.
- `sel_pipelined` in 1: 0 = non-pipelined engine, 1 = pipelined engine; latched at start.
- `input_addr` in 10: first input sample address; latched at start.
- `output_addr` in 10: first output address; latched at start.
- `sample_count` in 10: N, number of outputs; latched at start.
- `done` out 1: high from completion until the next accepted start or reset.
- `cycle_count` out 32: busy cycles of the last run.
- `non_pipe_state` out 4: non-pipelined FSM state.
- `pipe_state` out 3: pipelined FSM state.

## Operation
- **Memory.** Instance `memory`, 1024×8, contents zero at power-up and not cleared by `rst`.
  - Port A (`addr_a`, `we_a`, `data_in_a`, `data_out_a`): reads, with write capability for preload.
  - Port B (`addr_b`, `we_b`, `data_in_b`): writes.
  - Reads are synchronous with 1-cycle latency.
  - The top multiplexes the engine selected at start onto the top-level nets `mem_addr_a`, `mem_data_out_a`, `mem_addr_b`, `mem_data_in_b`, `mem_we_b`.
- **Filter function.** y[n] = Σ h[k]·x[n−k], k = 0..4, for n = 0..N−1.
  - x[i] is the signed 8-bit value at `input_addr + i`.
  - x[i] = 0 for i < 0.
  - Coefficients h = {16, 24, 48, 24, 16}, signed 8-bit, sum 128.
  - The accumulator is signed 16-bit and cannot overflow.
  - Result = accumulator >>> 7, truncated to 8 bits.
- **Output write.** y[n] is written to `output_addr + n`. All address arithmetic wraps modulo 1024.
- **Non-pipelined FSM** (instance `non_pipelined_filter`). States: IDLE=0, CLEAR=1, FETCH=2, MAC=3, WRITE=4, NEXT=5, DONE=6.
  - CLEAR: zero the accumulator, set tap=0.
  - FETCH: issue the read of x[n−tap].
  - MAC: accumulate the product, masked to 0 when tap > n. Go to FETCH while tap < 4, else to WRITE.
  - WRITE: port-B write of the result.
  - NEXT: increment n. Go to DONE if n == N, else to CLEAR.
  - Per sample this is 13 cycles.
- **Pipelined FSM** (instance `pipelined_filter`). States: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - RUN issues one read per cycle for N cycles.
  - Stage 1: 5-entry sample shift register (x0_s1..x4_s1), cleared at start.
  - Stage 2: five products plus sum (sum_s2).
  - Stage 3: result_s3 and output_valid_s3.
  - Each valid stage-3 result is written via port B the following cycle.
  - DRAIN lasts 4 cycles, then the FSM goes to DONE.
- **Idle engine.** The non-selected engine stays in IDLE.
- **start while busy.** Ignored.
- **N = 0.** Go straight to DONE with cycle_count = 1 and no writes.

## Timing
- **Reset values.** Both FSMs IDLE, `done`=0, `cycle_count`=0, state outputs 0, no memory write.
- **cycle_count.**
  - Cleared when start is accepted.
  - Increments on every cycle the active FSM is outside IDLE/DONE.
  - Holds in DONE.
- **Total cycles.** Non-pipelined = 13·N. Pipelined = N+4.
- **Pipelined latency.** Read address for sample k is driven in busy cycle k, and its write commits at the end of busy cycle k+4. Throughput is 1 sample per cycle.
- **done.** Rises on the first DONE cycle and falls in the cycle after an accepted start.
- **Reset mid-run.** Aborts immediately. Writes already committed remain in memory.

## Configuration
- `FIR_STATE_DEBUG_EN` defined: `non_pipe_state` and `pipe_state` output the live FSM encodings.
- Undefined: both outputs are tied to 0. Filter behaviour and cycle counts are unchanged.

## Structure
- **Shared package `fir_pkg`:** the coefficient array, tap count (5), address width (10), data width (8), accumulator width (16), and both state enums.
- **Sub-modules:** `dual_port_ram` (instance `memory`). Both engines are sub-modules `fir_non_pipelined` and `fir_pipelined`, instantiated in the top with the memory mux.

## Test plan
Common preload: memory [0..4] = 64, [10..14] = 32, all other locations 0.

- **Non-pipelined run.** Preload, then `sel_pipelined`=0, input 0, output 512, N=20. Required: [512..531] = 8, 20, 44, 56, 64, 56, 44, 20, 8, 0, 4, 10, 22, 28, 32, 28, 22, 10, 4, 0; cycle_count = 260.
- **Pipelined run.** Same preload and inputs, `sel_pipelined`=1, output 600. Required: identical values at [600..619]; cycle_count = 24.
- **Back-to-back starts.** Pulse start while `done` is high. Required: `done` drops the next cycle and cycle_count restarts from 0.
- **Busy and zero-length.** Start while busy: ignored. N=0: `done` after 1 cycle, cycle_count = 1, no writes.
- **Reset mid-run and wrap-around.** Assert `rst` during RUN/MAC: `done`=0, cycle_count=0, both FSMs IDLE. Output_addr = 1020 with N=8: writes wrap to addresses 1020..1023 then 0..3.
